// File: rtl/alu_io_pkg.sv
// Shared encodings for the DE2 ALU front end and its LED/LCD status display.
`timescale 1ns/1ps
package alu_io_pkg;

    localparam int ALU_SEL_W = 2;

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        SHOW    = 2'd3
    } state_e;

endpackage

// File: rtl/alu_operand_loader_if.sv
// Operand-entry bus between the board I/O (switches, key) and the operand loader.
`timescale 1ns/1ps
interface alu_operand_loader_if #(
    parameter int WIDTH = 4
);
    import alu_io_pkg::*;

    logic                 iKEY;
    logic [WIDTH-1:0]     iSW;
    logic [ALU_SEL_W-1:0] iSEL;
    logic [WIDTH-1:0]     oA;
    logic [WIDTH-1:0]     oB;
    logic [ALU_SEL_W-1:0] oSEL;
    logic                 oVALID;
    logic                 oDONE;
    logic [1:0]           oSTATE;

    modport master (
        output iKEY, iSW, iSEL,
        input  oA, oB, oSEL, oVALID, oDONE, oSTATE
    );

    modport slave (
        input  iKEY, iSW, iSEL,
        output oA, oB, oSEL, oVALID, oDONE, oSTATE
    );

endinterface

// File: rtl/key_debounce.sv
// Synchronizes and debounces one active-low push-button; emits a one-cycle press event
// on each accepted 1->0 transition of the key level.
`timescale 1ns/1ps
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic iCLK,
    input  logic iRST,
    input  logic iKEY,
    output logic oPRESS
);

    localparam int               CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_sync_vld;
    logic             r_level;
    logic [CNT_W-1:0] r_cnt;
    logic             r_armed;
    logic             r_press;

    logic w_differ;
    logic w_accept;

    assign w_differ = (r_sync2 != r_level);
    assign w_accept = w_differ && (r_cnt == CNT_MAX);

    // r_armed stays low until the synchronized key has been seen released, so a key
    // held down through reset cannot produce a press when it is finally accepted low.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the values from before the clock edge regardless of statement order.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_sync_vld <= 2'b00;
            r_level    <= 1'b1;
            r_cnt      <= '0;
            r_armed    <= 1'b0;
            r_press    <= 1'b0;
        end else begin
            r_sync1    <= iKEY;
            r_sync2    <= r_sync1;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_accept) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_armed <= r_armed | (r_sync_vld[1] & r_sync2);
            r_press <= w_accept & ~r_sync2 & r_armed;
        end
    end

    assign oPRESS = r_press;

endmodule

// File: rtl/alu_operand_loader.sv
// Steps through A / B / operation entry on successive debounced key presses and holds
// registered operands plus a one-cycle valid strobe for the downstream ALU.
`timescale 1ns/1ps
module alu_operand_loader
    import alu_io_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                iCLK,
    input  logic                iRST,
    alu_operand_loader_if.slave bus
);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_b;
    logic [ALU_SEL_W-1:0] r_sel;
    logic                 r_valid;
    logic                 r_done;

    logic w_press;
    logic w_load_a;
    logic w_load_b;
    logic w_load_sel;
    logic w_valid_nxt;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .iCLK  (iCLK),
        .iRST  (iRST),
        .iKEY  (bus.iKEY),
        .oPRESS(w_press)
    );

    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_load_a    = 1'b0;
        w_load_b    = 1'b0;
        w_load_sel  = 1'b0;
        w_valid_nxt = 1'b0;
        if (w_press) begin
            unique case (r_state)
                WAIT_A: begin
                    w_load_a    = 1'b1;
                    w_state_nxt = WAIT_B;
                end
                WAIT_B: begin
                    w_load_b    = 1'b1;
                    w_state_nxt = WAIT_OP;
                end
                WAIT_OP: begin
                    w_load_sel  = 1'b1;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = SHOW;
                end
                SHOW: begin
                    w_load_a    = 1'b1;
                    w_state_nxt = WAIT_B;
                end
                default: w_state_nxt = WAIT_A;
            endcase
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state <= WAIT_A;
            r_a     <= '0;
            r_b     <= '0;
            r_sel   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load_a)   r_a   <= bus.iSW;
            if (w_load_b)   r_b   <= bus.iSW;
            if (w_load_sel) r_sel <= bus.iSEL;
            r_valid <= w_valid_nxt;
            // Registered alongside the state so it tracks SHOW with no extra lag.
            r_done  <= (w_state_nxt == SHOW);
        end
    end

    assign bus.oA     = r_a;
    assign bus.oB     = r_b;
    assign bus.oSEL   = r_sel;
    assign bus.oVALID = r_valid;
    assign bus.oDONE  = r_done;
    assign bus.oSTATE = r_state;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Self-checking bench for alu_operand_loader with a short debounce window.
`timescale 1ns/1ps
module tb_alu_operand_loader;

    localparam int W = 4;
    localparam int D = 4;

    typedef struct {
        logic [3:0] sw;
        logic [1:0] sel;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        int         st;
        logic       done;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int   n_tests   = 0;
    int   n_fail    = 0;
    int   valid_cnt = 0;
    logic prev_valid = 1'b0;

    // Reference model: operand-entry progress tracked at the key-press level.
    int m_st    = 0;
    int m_a     = 0;
    int m_b     = 0;
    int m_sel   = 0;
    int m_valid = 0;

    alu_operand_loader_if #(.WIDTH(W)) bus ();

    alu_operand_loader #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .iCLK(clk),
        .iRST(rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input int a, input int b, input int sel,
                                 input int st, input int done);
        check({tag, "_oA"},     bus.oA,     a);
        check({tag, "_oB"},     bus.oB,     b);
        check({tag, "_oSEL"},   bus.oSEL,   sel);
        check({tag, "_oSTATE"}, bus.oSTATE, st);
        check({tag, "_oDONE"},  bus.oDONE,  done);
    endtask

    task automatic check_model(input string tag);
        check_outputs(tag, m_a, m_b, m_sel, m_st, (m_st == 3) ? 1 : 0);
    endtask

    task automatic model_press(input int sw, input int sel);
        case (m_st)
            0: begin m_a = sw; m_st = 1; end
            1: begin m_b = sw; m_st = 2; end
            2: begin m_sel = sel; m_st = 3; m_valid++; end
            default: begin m_a = sw; m_st = 1; end
        endcase
    endtask

    task automatic model_reset();
        m_st = 0; m_a = 0; m_b = 0; m_sel = 0;
    endtask

    // Clean or bouncy press, held past capture, then released long enough to re-arm.
    task automatic press(input logic [3:0] sw, input logic [1:0] sel, input bit bounce);
        @(posedge clk); #1;
        bus.iSW  = sw;
        bus.iSEL = sel;
        if (bounce) begin
            bus.iKEY = 1'b0;
            repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
            bus.iKEY = 1'b1;
            @(posedge clk); #1;
        end
        bus.iKEY = 1'b0;
        repeat (D + 4) @(posedge clk);
        #1;
        bus.iKEY = 1'b1;
        bus.iSW  = 4'($urandom);
        bus.iSEL = 2'($urandom);
        repeat (2 * D + 4) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (bus.oVALID === 1'b1) begin
            valid_cnt++;
            check("valid_single_cycle", prev_valid, 0);
        end
        prev_valid = bus.oVALID;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[2];
        int   v0;
        int   base_valid;
        logic [3:0] rsw;
        logic [1:0] rsel;

        vecs[0] = '{sw: 4'd5,  sel: 2'd1, a: 4'd3, b: 4'd5, op: 2'd0, st: 2, done: 1'b0};
        vecs[1] = '{sw: 4'd14, sel: 2'd2, a: 4'd3, b: 4'd5, op: 2'd2, st: 3, done: 1'b1};

        bus.iKEY = 1'b1;
        bus.iSW  = '0;
        bus.iSEL = '0;
        #1 rst = 1'b1;
        #1;
        check_outputs("reset", 0, 0, 0, 0, 0);
        check("reset_oVALID", bus.oVALID, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);

        // Latency: key low just after edge t, capture exactly at edge t+7.
        @(posedge clk); #1;
        bus.iSW  = 4'd3;
        bus.iKEY = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("latency_t6_oA", bus.oA, 0);
        check("latency_t6_oSTATE", bus.oSTATE, 0);
        @(posedge clk); #1;
        check("latency_t7_oA", bus.oA, 3);
        check("latency_t7_oSTATE", bus.oSTATE, 1);
        model_press(3, 0);
        bus.iKEY = 1'b1;
        bus.iSW  = 4'd0;
        repeat (2 * D + 4) @(posedge clk);
        #1;

        // Rest of the full sequence from the table.
        v0 = valid_cnt;
        for (int i = 0; i < 2; i++) begin
            press(vecs[i].sw, vecs[i].sel, 1'b0);
            model_press(int'(vecs[i].sw), int'(vecs[i].sel));
            check_outputs($sformatf("seq%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
                          vecs[i].st, vecs[i].done);
        end
        check("seq_valid_count", valid_cnt - v0, 1);

        // Switch isolation while in SHOW.
        v0 = valid_cnt;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            bus.iSW  = 4'(i);
            bus.iSEL = 2'(i);
        end
        repeat (3) @(posedge clk);
        #1;
        check_outputs("isolation", 3, 5, 2, 3, 1);
        check("isolation_valid_count", valid_cnt - v0, 0);

        // Restart from SHOW keeps B and SEL.
        press(4'd9, 2'd0, 1'b0);
        model_press(9, 0);
        check_outputs("restart", 9, 5, 2, 1, 0);

        // Bounce: 3 low, 1 high, then steady low; capture 7 edges after final fall.
        @(posedge clk); #1;
        bus.iSW  = 4'd6;
        bus.iKEY = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        bus.iKEY = 1'b1;
        @(posedge clk); #1;
        bus.iKEY = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("bounce_f6_oB", bus.oB, 5);
        check("bounce_f6_oSTATE", bus.oSTATE, 1);
        @(posedge clk); #1;
        check("bounce_f7_oB", bus.oB, 6);
        check("bounce_f7_oSTATE", bus.oSTATE, 2);
        model_press(6, 0);
        bus.iKEY = 1'b1;
        repeat (2 * D + 4) @(posedge clk);
        #1;

        // Asynchronous reset mid-count, key held low through release.
        @(posedge clk); #1;
        bus.iSW  = 4'd7;
        bus.iKEY = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_outputs("async_reset", 0, 0, 0, 0, 0);
        check("async_reset_oVALID", bus.oVALID, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        repeat (3 * D + 6) @(posedge clk);
        #1;
        check_outputs("held_key", 0, 0, 0, 0, 0);
        bus.iKEY = 1'b1;
        repeat (2 * D + 4) @(posedge clk);
        #1;
        press(4'd10, 2'd1, 1'b0);
        model_press(10, 1);
        check_model("after_reset");

        // Randomized presses, some with bounce, against the reference model.
        base_valid = valid_cnt;
        m_valid    = 0;
        for (int i = 0; i < 24; i++) begin
            rsw  = 4'($urandom_range(0, 15));
            rsel = 2'($urandom_range(0, 3));
            press(rsw, rsel, 1'($urandom_range(0, 1)));
            model_press(int'(rsw), int'(rsel));
            check_model($sformatf("rand%0d", i));
        end
        check("rand_valid_count", valid_cnt - base_valid, m_valid);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
